// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: port index, response metadata
// and the limits used by the arbiter and its response pipeline.
package mem_arb_pkg;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
    logic  is_read;
  } resp_meta_t;

  localparam int unsigned MaxExtraLatency = 4;
  localparam logic [31:0] ConflictCntMax  = 32'hFFFF_FFFF;

  function automatic port_e other_port(input port_e p);
    return (p == PORT_INSTR) ? PORT_DATA : PORT_INSTR;
  endfunction

endpackage

// File: rtl/mem_arb_resp_pipe.sv
// Extra response delay stages: shifts response metadata and captured read data
// by Depth cycles; Depth 0 is a straight pass-through.
module mem_arb_resp_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned Depth     = 0,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  resp_meta_t           meta_i,
  input  logic [DataWidth-1:0] data_i,
  output resp_meta_t           meta_o,
  output logic [DataWidth-1:0] data_o
);

  if (Depth == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign meta_o = meta_i;
    assign data_o = data_i;
  end else begin : g_regs
    resp_meta_t           meta_q [Depth];
    logic [DataWidth-1:0] data_q [Depth];

    // Reset drops every in-flight entry so nothing granted earlier can surface.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < Depth; i++) begin
          meta_q[i] <= '0;
          data_q[i] <= '0;
        end
      end else begin
        meta_q[0] <= meta_i;
        data_q[0] <= data_i;
        for (int i = 1; i < Depth; i++) begin
          meta_q[i] <= meta_q[i-1];
          data_q[i] <= data_q[i-1];
        end
      end
    end

    assign meta_o = meta_q[Depth-1];
    assign data_o = data_q[Depth-1];
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one always-ready single-port SRAM between an
// instruction port and a data port, with in-order per-port responses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned ExtraLatency = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,

  input  logic                   instr_req_i,
  input  logic                   instr_we_i,
  input  logic [AddrWidth-1:0]   instr_addr_i,
  input  logic [DataWidth-1:0]   instr_wdata_i,
  input  logic [DataWidth/8-1:0] instr_strb_i,
  output logic                   instr_gnt_o,
  output logic                   instr_rvalid_o,
  output logic [DataWidth-1:0]   instr_rdata_o,

  input  logic                   data_req_i,
  input  logic                   data_we_i,
  input  logic [AddrWidth-1:0]   data_addr_i,
  input  logic [DataWidth-1:0]   data_wdata_i,
  input  logic [DataWidth/8-1:0] data_strb_i,
  output logic                   data_gnt_o,
  output logic                   data_rvalid_o,
  output logic [DataWidth-1:0]   data_rdata_o,

  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  output logic [DataWidth/8-1:0] mem_strb_o,
  input  logic [DataWidth-1:0]   mem_rdata_i,

  output logic [31:0]            conflict_cnt_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned PipeDepth =
    (ExtraLatency > MaxExtraLatency) ? MaxExtraLatency : ExtraLatency;

  // Handshake: a port holds req (and its fields) until it sees gnt in the same
  // cycle; each grant yields exactly one rvalid pulse on that port, in grant
  // order, 1+ExtraLatency cycles later. Nothing ungranted is ever stored.

  port_e                last_q;
  port_e                conflict_winner;
  port_e                gnt_port;
  logic                 both_req;
  logic                 instr_gnt;
  logic                 data_gnt;
  logic                 any_gnt;
  logic                 mem_we;
  logic [31:0]          conflict_cnt_q;
  resp_meta_t           sram_meta_q;
  resp_meta_t           resp_meta;
  logic [DataWidth-1:0] pipe_data;
  logic [DataWidth-1:0] resp_data;
  logic                 instr_rvalid;
  logic                 data_rvalid;

  assign both_req        = instr_req_i & data_req_i;
  assign conflict_winner = other_port(last_q);

  always_comb begin
    instr_gnt = 1'b0;
    data_gnt  = 1'b0;
    if (rst_ni) begin
      if (both_req) begin
        instr_gnt = (conflict_winner == PORT_INSTR);
        data_gnt  = (conflict_winner == PORT_DATA);
      end else begin
        instr_gnt = instr_req_i;
        data_gnt  = data_req_i;
      end
    end
  end

  assign any_gnt     = instr_gnt | data_gnt;
  assign gnt_port    = data_gnt ? PORT_DATA : PORT_INSTR;
  assign instr_gnt_o = instr_gnt;
  assign data_gnt_o  = data_gnt;

  always_comb begin
    mem_we      = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_strb_o  = '0;
    if (instr_gnt) begin
      mem_we      = instr_we_i;
      mem_addr_o  = instr_addr_i;
      mem_wdata_o = instr_wdata_i;
      mem_strb_o  = instr_strb_i;
    end else if (data_gnt) begin
      mem_we      = data_we_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
      mem_strb_o  = data_strb_i;
    end
  end

  assign mem_req_o = any_gnt;
  assign mem_we_o  = mem_we;

  // Resetting to "data granted last" makes the instruction port win first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= PORT_DATA;
    end else if (any_gnt) begin
      last_q <= gnt_port;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_cnt_q <= '0;
    end else if (both_req && (conflict_cnt_q != ConflictCntMax)) begin
      conflict_cnt_q <= conflict_cnt_q + 32'd1;
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;

  // First stage mirrors the SRAM's own read latency; read data joins here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sram_meta_q <= '0;
    end else begin
      sram_meta_q <= '{valid: any_gnt, port: gnt_port, is_read: any_gnt & ~mem_we};
    end
  end

  assign pipe_data = (sram_meta_q.valid && sram_meta_q.is_read) ? mem_rdata_i : '0;

  mem_arb_resp_pipe #(
    .Depth     (PipeDepth),
    .DataWidth (DataWidth)
  ) u_resp_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .meta_i (sram_meta_q),
    .data_i (pipe_data),
    .meta_o (resp_meta),
    .data_o (resp_data)
  );

  assign instr_rvalid   = resp_meta.valid && (resp_meta.port == PORT_INSTR);
  assign data_rvalid    = resp_meta.valid && (resp_meta.port == PORT_DATA);
  assign instr_rvalid_o = instr_rvalid;
  assign data_rvalid_o  = data_rvalid;
  assign instr_rdata_o  = instr_rvalid ? resp_data : '0;
  assign data_rdata_o   = data_rvalid ? resp_data : '0;

  logic unused_strb_width;
  assign unused_strb_width = (StrbWidth == 0);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (ExtraLatency 0, 2, 3) share one
// stimulus stream and are compared every cycle against a transaction-level model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        instr_req, instr_we, data_req, data_we;
  logic [31:0] instr_addr, instr_wdata, data_addr, data_wdata;
  logic [3:0]  instr_strb, data_strb;

  logic        instr_gnt [NDUT], instr_rvalid [NDUT], data_gnt [NDUT], data_rvalid [NDUT];
  logic [31:0] instr_rdata [NDUT], data_rdata [NDUT];
  logic        mem_req [NDUT], mem_we [NDUT];
  logic [31:0] mem_addr [NDUT], mem_wdata [NDUT], sram_rd [NDUT], conflict_cnt [NDUT];
  logic [3:0]  mem_strb [NDUT];

  mem_port_arbiter #(.ExtraLatency(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req), .instr_we_i(instr_we), .instr_addr_i(instr_addr),
    .instr_wdata_i(instr_wdata), .instr_strb_i(instr_strb), .instr_gnt_o(instr_gnt[0]),
    .instr_rvalid_o(instr_rvalid[0]), .instr_rdata_o(instr_rdata[0]),
    .data_req_i(data_req), .data_we_i(data_we), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_strb_i(data_strb), .data_gnt_o(data_gnt[0]),
    .data_rvalid_o(data_rvalid[0]), .data_rdata_o(data_rdata[0]),
    .mem_req_o(mem_req[0]), .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]),
    .mem_wdata_o(mem_wdata[0]), .mem_strb_o(mem_strb[0]), .mem_rdata_i(sram_rd[0]),
    .conflict_cnt_o(conflict_cnt[0]));

  mem_port_arbiter #(.ExtraLatency(2)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req), .instr_we_i(instr_we), .instr_addr_i(instr_addr),
    .instr_wdata_i(instr_wdata), .instr_strb_i(instr_strb), .instr_gnt_o(instr_gnt[1]),
    .instr_rvalid_o(instr_rvalid[1]), .instr_rdata_o(instr_rdata[1]),
    .data_req_i(data_req), .data_we_i(data_we), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_strb_i(data_strb), .data_gnt_o(data_gnt[1]),
    .data_rvalid_o(data_rvalid[1]), .data_rdata_o(data_rdata[1]),
    .mem_req_o(mem_req[1]), .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]),
    .mem_wdata_o(mem_wdata[1]), .mem_strb_o(mem_strb[1]), .mem_rdata_i(sram_rd[1]),
    .conflict_cnt_o(conflict_cnt[1]));

  mem_port_arbiter #(.ExtraLatency(3)) dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req), .instr_we_i(instr_we), .instr_addr_i(instr_addr),
    .instr_wdata_i(instr_wdata), .instr_strb_i(instr_strb), .instr_gnt_o(instr_gnt[2]),
    .instr_rvalid_o(instr_rvalid[2]), .instr_rdata_o(instr_rdata[2]),
    .data_req_i(data_req), .data_we_i(data_we), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_strb_i(data_strb), .data_gnt_o(data_gnt[2]),
    .data_rvalid_o(data_rvalid[2]), .data_rdata_o(data_rdata[2]),
    .mem_req_o(mem_req[2]), .mem_we_o(mem_we[2]), .mem_addr_o(mem_addr[2]),
    .mem_wdata_o(mem_wdata[2]), .mem_strb_o(mem_strb[2]), .mem_rdata_i(sram_rd[2]),
    .conflict_cnt_o(conflict_cnt[2]));

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    case (d)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [31:0] init_word(input int i);
    return 32'hA500_0000 ^ (i * 32'h0001_0203);
  endfunction

  // One SRAM per instance: latch the request away from the edge, apply at posedge.
  logic [31:0] sram [NDUT][16];
  logic        l_req [NDUT], l_we [NDUT];
  logic [31:0] l_addr [NDUT], l_wdata [NDUT];
  logic [3:0]  l_strb [NDUT];

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < 16; i++) sram[d][i] = init_word(i);
      sram_rd[d] = '0;
    end
    forever begin
      @(negedge clk); #3;
      for (int d = 0; d < NDUT; d++) begin
        l_req[d] = mem_req[d]; l_we[d] = mem_we[d]; l_addr[d] = mem_addr[d];
        l_wdata[d] = mem_wdata[d]; l_strb[d] = mem_strb[d];
      end
      @(posedge clk);
      for (int d = 0; d < NDUT; d++) begin
        if (l_req[d] && l_we[d]) begin
          for (int b = 0; b < 4; b++)
            if (l_strb[d][b]) sram[d][l_addr[d][5:2]][8*b +: 8] = l_wdata[d][8*b +: 8];
          sram_rd[d] <= $urandom;
        end else if (l_req[d]) begin
          sram_rd[d] <= sram[d][l_addr[d][5:2]];
        end else begin
          sram_rd[d] <= $urandom;
        end
      end
    end
  end

  // Transaction-level model: who wins, what reaches memory, what comes back when.
  typedef struct {
    int          due;
    bit          on_data;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q [NDUT][$];
  logic [31:0] mm [16];
  bit          last_was_data = 1'b1;
  logic [31:0] m_cnt = '0;
  int          cyc = 0;
  bit          chk_en = 1'b0;
  bit          preload_pend = 1'b0;

  logic        e_gi, e_gd, e_we, e_iv, e_dv;
  logic [31:0] e_addr, e_wdata, e_ird, e_drd, rd_val;
  logic [3:0]  e_strb;
  exp_t        ent;

  initial for (int i = 0; i < 16; i++) mm[i] = init_word(i);

  always begin
    @(negedge clk); #2;
    if (chk_en) begin
      if (!rst_n) begin
        last_was_data = 1'b1;
        m_cnt = '0;
        for (int d = 0; d < NDUT; d++) exp_q[d].delete();
      end
      if (preload_pend) begin
        m_cnt = 32'hFFFF_FFFE;
        preload_pend = 1'b0;
      end
      e_gi = rst_n && instr_req && (!data_req || last_was_data);
      e_gd = rst_n && data_req && !e_gi;
      e_we = 1'b0; e_addr = '0; e_wdata = '0; e_strb = '0;
      if (e_gi) begin
        e_we = instr_we; e_addr = instr_addr; e_wdata = instr_wdata; e_strb = instr_strb;
      end else if (e_gd) begin
        e_we = data_we; e_addr = data_addr; e_wdata = data_wdata; e_strb = data_strb;
      end
      for (int d = 0; d < NDUT; d++) begin
        e_iv = 1'b0; e_dv = 1'b0; e_ird = '0; e_drd = '0;
        if (exp_q[d].size() > 0 && exp_q[d][0].due == cyc) begin
          ent = exp_q[d].pop_front();
          if (ent.on_data) begin e_dv = 1'b1; e_drd = ent.data; end
          else begin e_iv = 1'b1; e_ird = ent.data; end
        end
        check($sformatf("d%0d instr_gnt c%0d", d, cyc), instr_gnt[d], e_gi);
        check($sformatf("d%0d data_gnt c%0d", d, cyc), data_gnt[d], e_gd);
        check($sformatf("d%0d mem_req c%0d", d, cyc), mem_req[d], e_gi | e_gd);
        check($sformatf("d%0d mem_we c%0d", d, cyc), mem_we[d], e_we);
        check($sformatf("d%0d mem_addr c%0d", d, cyc), mem_addr[d], e_addr);
        check($sformatf("d%0d mem_wdata c%0d", d, cyc), mem_wdata[d], e_wdata);
        check($sformatf("d%0d mem_strb c%0d", d, cyc), mem_strb[d], e_strb);
        check($sformatf("d%0d conflict_cnt c%0d", d, cyc), conflict_cnt[d], m_cnt);
        check($sformatf("d%0d instr_rvalid c%0d", d, cyc), instr_rvalid[d], e_iv);
        check($sformatf("d%0d instr_rdata c%0d", d, cyc), instr_rdata[d], e_ird);
        check($sformatf("d%0d data_rvalid c%0d", d, cyc), data_rvalid[d], e_dv);
        check($sformatf("d%0d data_rdata c%0d", d, cyc), data_rdata[d], e_drd);
      end
      if (e_gi || e_gd) begin
        rd_val = e_we ? 32'h0 : mm[e_addr[5:2]];
        for (int d = 0; d < NDUT; d++) begin
          ent.due = cyc + 1 + lat_of(d);
          ent.on_data = e_gd;
          ent.data = rd_val;
          exp_q[d].push_back(ent);
        end
        if (e_we)
          for (int b = 0; b < 4; b++)
            if (e_strb[b]) mm[e_addr[5:2]][8*b +: 8] = e_wdata[8*b +: 8];
        last_was_data = e_gd;
      end
      if (rst_n && instr_req && data_req && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
    cyc++;
  end

  // Driver tasks.
  task automatic set_idle();
    instr_req = 1'b0; instr_we = 1'b0; instr_addr = '0; instr_wdata = '0; instr_strb = '0;
    data_req  = 1'b0; data_we  = 1'b0; data_addr  = '0; data_wdata  = '0; data_strb  = '0;
  endtask

  task automatic drive_i(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] strb);
    instr_req = 1'b1; instr_we = we; instr_addr = addr; instr_wdata = wd; instr_strb = strb;
  endtask

  task automatic drive_d(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] strb);
    data_req = 1'b1; data_we = we; data_addr = addr; data_wdata = wd; data_strb = strb;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(negedge clk); set_idle(); end
  endtask

  bit i_pend, d_pend;

  initial begin
    set_idle();
    // Reset with both requests high: no grant may leak out.
    @(negedge clk);
    rst_n = 1'b0; chk_en = 1'b1;
    instr_req = 1'b1; data_req = 1'b1;
    #1;
    check("reset instr_gnt", instr_gnt[0], 1'b0);
    check("reset data_gnt", data_gnt[0], 1'b0);
    check("reset mem_req", mem_req[0], 1'b0);
    idle_cycles(2);

    // Conflict held four cycles: I, D, I, D, then four conflicts counted.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rst_n = 1'b1;
      drive_i(1'b0, $urandom, 32'h0, 4'h0);
      drive_d(1'b0, $urandom, 32'h0, 4'h0);
      #1;
      check($sformatf("rr instr_gnt %0d", k), instr_gnt[0], (k % 2 == 0));
      check($sformatf("rr data_gnt %0d", k), data_gnt[0], (k % 2 == 1));
    end
    @(negedge clk); set_idle(); #1;
    check("conflict cnt after 4", conflict_cnt[0], 32'd4);
    idle_cycles(6);

    // Write then read back on the data port; preload word 4 for the fetch.
    @(negedge clk); set_idle(); drive_d(1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk); set_idle(); drive_d(1'b0, 32'h0000_0020, 32'h0, 4'h0); #1;
    check("wr rvalid", data_rvalid[0], 1'b1);
    check("wr rdata zero", data_rdata[0], 32'h0);
    @(negedge clk); set_idle(); drive_d(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'hF); #1;
    check("rd rvalid", data_rvalid[0], 1'b1);
    check("rd rdata", data_rdata[0], 32'hDEAD_BEEF);
    @(negedge clk); set_idle(); drive_i(1'b0, 32'h8000_0010, 32'h0, 4'h0); #1;
    check("fetch gnt", instr_gnt[0], 1'b1);
    check("fetch mem_addr", mem_addr[0], 32'h8000_0010);
    @(negedge clk); set_idle(); #1;
    check("fetch rvalid", instr_rvalid[0], 1'b1);
    check("fetch rdata", instr_rdata[0], 32'hCAFE_F00D);
    idle_cycles(6);

    // Three back-to-back grants through the 3-stage instance.
    @(negedge clk); set_idle(); drive_i(1'b0, 32'h0000_0004, 32'h0, 4'h0);
    @(negedge clk); set_idle(); drive_d(1'b1, 32'h0000_0008, 32'h1234_5678, 4'h3);
    @(negedge clk); set_idle(); drive_i(1'b0, 32'h0000_0008, 32'h0, 4'h0);
    for (int k = 3; k < 8; k++) begin
      @(negedge clk); set_idle(); #1;
      check($sformatf("lat3 instr_rvalid g+%0d", k), instr_rvalid[2], (k == 4 || k == 6));
      check($sformatf("lat3 data_rvalid g+%0d", k), data_rvalid[2], (k == 5));
    end
    idle_cycles(4);

    // Reset one cycle after a grant: the response must never appear.
    @(negedge clk); set_idle(); drive_i(1'b0, 32'h0000_000C, 32'h0, 4'h0);
    @(negedge clk); set_idle(); rst_n = 1'b0;
    @(negedge clk); set_idle();
    @(negedge clk); set_idle(); rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); set_idle(); #1;
      check($sformatf("post-reset instr_rvalid %0d", k), instr_rvalid[1], 1'b0);
      check($sformatf("post-reset data_rvalid %0d", k), data_rvalid[1], 1'b0);
    end
    @(negedge clk);
    drive_i(1'b0, $urandom, 32'h0, 4'h0);
    drive_d(1'b0, $urandom, 32'h0, 4'h0);
    #1;
    check("post-reset conflict instr_gnt", instr_gnt[1], 1'b1);
    check("post-reset conflict data_gnt", data_gnt[1], 1'b0);
    @(negedge clk); instr_req = 1'b0;
    idle_cycles(4);

    // Random traffic; an ungranted requester keeps its request unchanged.
    i_pend = 1'b0; d_pend = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 99) != 0);
      if (!i_pend) begin
        instr_req = ($urandom_range(0, 2) != 0); instr_we = $urandom_range(0, 1);
        instr_addr = $urandom; instr_wdata = $urandom; instr_strb = $urandom_range(0, 15);
      end
      if (!d_pend) begin
        data_req = ($urandom_range(0, 2) != 0); data_we = $urandom_range(0, 1);
        data_addr = $urandom; data_wdata = $urandom; data_strb = $urandom_range(0, 15);
      end
      #1;
      i_pend = instr_req && !instr_gnt[0];
      d_pend = data_req && !data_gnt[0];
    end

    // Saturation: preload near the top, then three conflict cycles.
    @(negedge clk);
    rst_n = 1'b1; set_idle();
    force dut0.conflict_cnt_q = 32'hFFFF_FFFE;
    force dut1.conflict_cnt_q = 32'hFFFF_FFFE;
    force dut2.conflict_cnt_q = 32'hFFFF_FFFE;
    preload_pend = 1'b1;
    #1;
    release dut0.conflict_cnt_q;
    release dut1.conflict_cnt_q;
    release dut2.conflict_cnt_q;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_i(1'b0, 32'h0000_0030, 32'h0, 4'h0);
      drive_d(1'b0, 32'h0000_0034, 32'h0, 4'h0);
    end
    @(negedge clk); set_idle(); #1;
    for (int d = 0; d < NDUT; d++)
      check($sformatf("d%0d cnt saturated", d), conflict_cnt[d], 32'hFFFF_FFFF);
    idle_cycles(8);
    #3;
    for (int d = 0; d < NDUT; d++)
      check($sformatf("d%0d responses drained", d), exp_q[d].size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, port and memory address width.
REQ-002 SHALL have parameter DataWidth, default 32, data width; strobe width is DataWidth/8.
REQ-003 SHALL have parameter ExtraLatency, default 0, legal range 0..4, extra response register stages beyond the memory's 1-cycle read latency.
REQ-004 SHALL have one clock; reset is asynchronous and active-low (clk_i, rst_ni).
REQ-005 clk_i  input  1  clock, all state on rising edge.
REQ-006 rst_ni  input  1  asynchronous active-low reset.
REQ-007 instr_req_i  input  1  instruction port request; instr_we_i  input  1  write enable.
REQ-008 instr_addr_i  input  AddrWidth; instr_wdata_i  input  DataWidth; instr_strb_i  input  DataWidth/8.
REQ-009 instr_gnt_o  output  1  request accepted this cycle; instr_rvalid_o  output  1  response valid; instr_rdata_o  output  DataWidth  read data.
REQ-010 data_req_i, data_we_i, data_addr_i, data_wdata_i, data_strb_i, data_gnt_o, data_rvalid_o, data_rdata_o: same directions, widths and meanings as the instruction port.
REQ-011 mem_req_o  output  1; mem_we_o  output  1; mem_addr_o  output  AddrWidth; mem_wdata_o  output  DataWidth; mem_strb_o  output  DataWidth/8: single-port SRAM request.
REQ-012 mem_rdata_i  input  DataWidth  SRAM read data, valid exactly 1 cycle after mem_req_o; SRAM always ready.
REQ-013 conflict_cnt_o  output  32  saturating count of cycles in which both ports requested.

Function
REQ-014 At most one port SHALL be granted per cycle; gnt is combinational from req and the priority state.
REQ-015 Single requester: granted in the same cycle.
REQ-016 Both requesting: the port not granted most recently wins (round-robin); after reset the instruction port wins first.
REQ-017 The priority pointer SHALL update only on a cycle with a grant, to the port just granted.
REQ-018 mem_req_o SHALL equal OR of grants; mem_we/addr/wdata/strb SHALL mux from the granted port, and SHALL be zero when there is no grant.
REQ-019 Every granted transaction, reads and writes alike, SHALL produce exactly one rvalid pulse on its own port, 1+ExtraLatency cycles after the grant cycle.
REQ-020 rdata_o of the responding port SHALL carry mem_rdata_i, captured when the SRAM presents it, for reads; SHALL be zero for writes; SHALL be zero on the non-responding port.
REQ-021 Responses SHALL stay in grant order; the pipeline accepts one new entry per cycle, so back-to-back grants never stall.
REQ-022 A requester not granted SHALL hold its request; the arbiter SHALL NOT latch ungranted requests.
REQ-023 conflict_cnt_o SHALL increment by 1 on each cycle with both req high, and SHALL saturate at 0xFFFFFFFF.

Reset
REQ-024 On rst_ni low, asynchronously: priority to instruction port, all in-flight response entries dropped, rvalid_o both 0, rdata_o both 0, conflict_cnt_o 0.
REQ-025 Transactions granted before a mid-operation reset SHALL never produce rvalid after reset release.
REQ-026 gnt_o and mem_*_o SHALL be 0 while in reset regardless of req inputs.

Structure
REQ-027 Package mem_arb_pkg SHALL hold the port-index enum (PORT_INSTR, PORT_DATA) and a response-metadata struct (valid, port, is_read).
REQ-028 Sub-module mem_arb_resp_pipe SHALL implement the ExtraLatency-deep metadata/data shift register; ExtraLatency=0 means pass-through.

Verification
REQ-029 Only instr_req=1, addr 0x80000010, we=0, ExtraLatency=0 -> instr_gnt same cycle, mem_addr_o=0x80000010, instr_rvalid next cycle with SRAM word.
REQ-030 Both req held high for 4 cycles after reset -> grants I,D,I,D, and conflict_cnt_o=4.
REQ-031 data write 0xDEADBEEF, strb 0xF, then data read same address -> write rvalid with rdata 0, read rvalid with rdata 0xDEADBEEF.
REQ-032 ExtraLatency=3, grants on 3 consecutive cycles -> 3 rvalid pulses on cycles grant+4, in order, correct port each.
REQ-033 Assert rst_ni low 1 cycle after a grant with ExtraLatency=2 -> no rvalid after release; first post-reset conflict grants instruction port.
REQ-034 Force conflict_cnt to 0xFFFFFFFE, 3 conflict cycles -> counter holds 0xFFFFFFFF.
